// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for the IF/EX pipeline register and the PC.
// It detects load-use hazards against the instruction in EX and reacts to
// branches resolved taken in EX. From these it generates the PC write-enable,
// the IF/EX write-enable and flush, and the EX bubble. A busy data memory
// freezes the whole front end. Two saturating counters record load-stall
// cycles and taken-branch flush events.
//
// Parameters
//   STALL_CYCLES    bubble cycles per load-use hazard (1..15)
//   BRANCH_PENALTY  IF/EX flush cycles per taken branch (1..15)
//
// Ports
//   clk            clock, rising edge
//   Reset          synchronous, active-high reset
//   id_rs, id_rt   source register fields of the instruction in ID
//   id_uses_rt     ID instruction reads rt
//   ex_rd          destination register of the instruction in EX
//   ex_mem_read    EX instruction is a load
//   branch_taken   branch in EX resolved taken this cycle
//   mem_busy       data memory not ready
//   pc_write_en    PC loads its next value at the edge
//   ifex_write_en  IF/EX register write-enable
//   ifex_flush     IF/EX register loads a NOP at the edge
//   ex_bubble      ID/EX control is zeroed at the edge
//   freeze         whole front end held
//   state          0 = RUN, 1 = LOAD_STALL, 2 = FLUSH
//   stall_cnt      load-stall cycle count, saturating
//   flush_cnt      taken-branch flush event count, saturating
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int STALL_CYCLES   = 1,
    parameter int BRANCH_PENALTY = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write_en,
    output logic        ifex_write_en,
    output logic        ifex_flush,
    output logic        ex_bubble,
    output logic        freeze,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    // The first stall/flush cycle is spent in RUN, so the down-counter only
    // has to cover the remaining N-1 cycles and ends at zero.
    localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 2);
    localparam logic [3:0] FLUSH_RELOAD = 4'(BRANCH_PENALTY - 2);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       stall_inc;
    logic       flush_inc;
    logic       take_branch;
    logic       hz;

    // Register 0 is hard-wired zero, so a load targeting it never hazards.
    assign hz = ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign state = state_q;

    // Mealy control: outputs and next state from current state and inputs.
    // A busy memory leaves next-state equal to current state, so everything
    // simply holds for the busy duration.
    always_comb begin
        pc_write_en   = 1'b1;
        ifex_write_en = 1'b1;
        ifex_flush    = 1'b0;
        ex_bubble     = 1'b0;
        freeze        = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        take_branch   = 1'b0;

        if (Reset) begin
            pc_write_en   = 1'b0;
            ifex_write_en = 1'b0;
            ifex_flush    = 1'b1;
            ex_bubble     = 1'b1;
        end else if (mem_busy) begin
            freeze        = 1'b1;
            pc_write_en   = 1'b0;
            ifex_write_en = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // A hazard alongside a taken branch belongs to a
                    // wrong-path instruction and is dropped.
                    if (branch_taken) begin
                        take_branch = 1'b1;
                    end else if (hz) begin
                        pc_write_en   = 1'b0;
                        ifex_write_en = 1'b0;
                        ex_bubble     = 1'b1;
                        stall_inc     = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                end
                LOAD_STALL: begin
                    if (branch_taken) begin
                        take_branch = 1'b1;
                    end else begin
                        pc_write_en   = 1'b0;
                        ifex_write_en = 1'b0;
                        ex_bubble     = 1'b1;
                        stall_inc     = 1'b1;
                        if (cnt_q == 4'd0) begin
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    ifex_flush = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase

            // Shared by RUN and by a stall aborted from LOAD_STALL.
            if (take_branch) begin
                ifex_flush = 1'b1;
                flush_inc  = 1'b1;
                if (BRANCH_PENALTY > 1) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_RELOAD;
                end else begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_inc && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_inc && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Three controller instances share one set of inputs:
//   dut 0: STALL_CYCLES=2, BRANCH_PENALTY=2
//   dut 1: STALL_CYCLES=3, BRANCH_PENALTY=3
//   dut 2: STALL_CYCLES=1, BRANCH_PENALTY=1
// Each table row drives one cycle and names the instance whose outputs it
// checks. Inputs change on the falling edge; outputs are sampled 1 time unit
// later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       Reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       branch_taken;
    logic       mem_busy;

    logic        pc_w  [3];
    logic        we_w  [3];
    logic        fl_w  [3];
    logic        bub_w [3];
    logic        frz_w [3];
    logic [1:0]  st_w  [3];
    logic [15:0] sc_w  [3];
    logic [15:0] fc_w  [3];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_CYCLES(2), .BRANCH_PENALTY(2)) u_a (
        .clk(clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write_en(pc_w[0]), .ifex_write_en(we_w[0]), .ifex_flush(fl_w[0]),
        .ex_bubble(bub_w[0]), .freeze(frz_w[0]), .state(st_w[0]),
        .stall_cnt(sc_w[0]), .flush_cnt(fc_w[0])
    );

    pipe_hazard_ctrl #(.STALL_CYCLES(3), .BRANCH_PENALTY(3)) u_b (
        .clk(clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write_en(pc_w[1]), .ifex_write_en(we_w[1]), .ifex_flush(fl_w[1]),
        .ex_bubble(bub_w[1]), .freeze(frz_w[1]), .state(st_w[1]),
        .stall_cnt(sc_w[1]), .flush_cnt(fc_w[1])
    );

    pipe_hazard_ctrl #(.STALL_CYCLES(1), .BRANCH_PENALTY(1)) u_c (
        .clk(clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write_en(pc_w[2]), .ifex_write_en(we_w[2]), .ifex_flush(fl_w[2]),
        .ex_bubble(bub_w[2]), .freeze(frz_w[2]), .state(st_w[2]),
        .stall_cnt(sc_w[2]), .flush_cnt(fc_w[2])
    );

    typedef struct packed {
        logic        pc;
        logic        we;
        logic        fl;
        logic        bub;
        logic        frz;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } outs_t;

    typedef enum int {
        K_IDLE, K_RST, K_HZ, K_RD0, K_RTOFF, K_HZRT, K_BRHZ, K_BR, K_BUSY, K_BUSYBR
    } kind_t;

    typedef struct {
        string      name;
        int         sel;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        bit         full;
        outs_t      exp;
    } vec_t;

    typedef struct {
        string name;
        int    sel;
        bit    full;
        outs_t exp;
    } sb_t;

    // Control output patterns {pc_write_en, ifex_write_en, ifex_flush, ex_bubble, freeze}
    localparam logic [4:0] C_RST   = 5'b00110;
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11100;
    localparam logic [4:0] C_FRZ   = 5'b00001;

    sb_t  sbq[$];
    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(string name, int sel, kind_t k, bit full,
                                logic [4:0] ctl, logic [1:0] st,
                                logic [15:0] sc, logic [15:0] fc);
        vec_t v;
        v.name = name;
        v.sel  = sel;
        v.full = full;
        v.rst  = 1'b0;
        v.rs   = 5'd1;
        v.rt   = 5'd2;
        v.ur   = 1'b1;
        v.rd   = 5'd3;
        v.mr   = 1'b0;
        v.br   = 1'b0;
        v.busy = 1'b0;
        case (k)
            K_RST:    v.rst = 1'b1;
            K_HZ:     begin v.mr = 1'b1; v.rd = 5'd5; v.rs = 5'd5; end
            K_RD0:    begin v.mr = 1'b1; v.rd = 5'd0; v.rs = 5'd0; end
            K_RTOFF:  begin v.mr = 1'b1; v.rd = 5'd5; v.rt = 5'd5; v.ur = 1'b0; end
            K_HZRT:   begin v.mr = 1'b1; v.rd = 5'd7; v.rt = 5'd7; end
            K_BRHZ:   begin v.mr = 1'b1; v.rd = 5'd5; v.rs = 5'd5; v.br = 1'b1; end
            K_BR:     v.br = 1'b1;
            K_BUSY:   v.busy = 1'b1;
            K_BUSYBR: begin v.busy = 1'b1; v.br = 1'b1; end
            default:  ;
        endcase
        v.exp = {ctl, st, sc, fc};
        return v;
    endfunction

    function automatic outs_t getOuts(int s);
        outs_t o;
        o.pc  = pc_w[s];
        o.we  = we_w[s];
        o.fl  = fl_w[s];
        o.bub = bub_w[s];
        o.frz = frz_w[s];
        o.st  = st_w[s];
        o.sc  = sc_w[s];
        o.fc  = fc_w[s];
        return o;
    endfunction

    task automatic drive(input vec_t v);
        Reset        = v.rst;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rt   = v.ur;
        ex_rd        = v.rd;
        ex_mem_read  = v.mr;
        branch_taken = v.br;
        mem_busy     = v.busy;
    endtask

    task automatic applyStimulus(input vec_t v);
        sb_t e;
        @(negedge clk);
        drive(v);
        e.name = v.name;
        e.sel  = v.sel;
        e.full = v.full;
        e.exp  = v.exp;
        sbq.push_back(e);
    endtask

    task automatic cmpField(input string name, input string field, input int sel,
                            input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s.%s dut%0d actual=%h required=%h",
                     name, field, sel, act, req);
        end
    endtask

    task automatic checkOutput();
        sb_t   e;
        outs_t a;
        #1;
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sbq.pop_front();
        a = getOuts(e.sel);
        cmpField(e.name, "pc_write_en",   e.sel, 16'(a.pc),  16'(e.exp.pc));
        cmpField(e.name, "ifex_write_en", e.sel, 16'(a.we),  16'(e.exp.we));
        cmpField(e.name, "ifex_flush",    e.sel, 16'(a.fl),  16'(e.exp.fl));
        cmpField(e.name, "ex_bubble",     e.sel, 16'(a.bub), 16'(e.exp.bub));
        cmpField(e.name, "freeze",        e.sel, 16'(a.frz), 16'(e.exp.frz));
        if (e.full) begin
            cmpField(e.name, "state",     e.sel, 16'(a.st), 16'(e.exp.st));
            cmpField(e.name, "stall_cnt", e.sel, a.sc, e.exp.sc);
            cmpField(e.name, "flush_cnt", e.sel, a.fc, e.exp.fc);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        vec_t hzv;

        Reset        = 1'b1;
        id_rs        = 5'd1;
        id_rt        = 5'd2;
        id_uses_rt   = 1'b1;
        ex_rd        = 5'd3;
        ex_mem_read  = 1'b0;
        branch_taken = 1'b0;
        mem_busy     = 1'b0;

        // Reset held two cycles, then release (dut 0)
        vecs.push_back(mk("rst0",      0, K_RST,    0, C_RST,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("rst1",      0, K_RST,    1, C_RST,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("run0",      0, K_IDLE,   1, C_RUN,   2'd0, 16'd0, 16'd0));
        // Load-use on rs, two stall cycles
        vecs.push_back(mk("hz_rs",     0, K_HZ,     1, C_STALL, 2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("hz_rs2",    0, K_IDLE,   1, C_STALL, 2'd1, 16'd1, 16'd0));
        vecs.push_back(mk("hz_end",    0, K_IDLE,   1, C_RUN,   2'd0, 16'd2, 16'd0));
        // No hazard: rd==0, or rt match with rt unused
        vecs.push_back(mk("nohz_rd0",  0, K_RD0,    1, C_RUN,   2'd0, 16'd2, 16'd0));
        vecs.push_back(mk("nohz_rt",   0, K_RTOFF,  1, C_RUN,   2'd0, 16'd2, 16'd0));
        // Load-use on rt
        vecs.push_back(mk("hz_rt",     0, K_HZRT,   1, C_STALL, 2'd0, 16'd2, 16'd0));
        vecs.push_back(mk("hz_rt2",    0, K_IDLE,   1, C_STALL, 2'd1, 16'd3, 16'd0));
        vecs.push_back(mk("hz_rt_end", 0, K_IDLE,   1, C_RUN,   2'd0, 16'd4, 16'd0));
        // Branch together with hazard: two flush cycles, no stall
        vecs.push_back(mk("br_hz",     0, K_BRHZ,   1, C_FLUSH, 2'd0, 16'd4, 16'd0));
        vecs.push_back(mk("br_fl2",    0, K_IDLE,   1, C_FLUSH, 2'd2, 16'd4, 16'd1));
        vecs.push_back(mk("br_end",    0, K_IDLE,   1, C_RUN,   2'd0, 16'd4, 16'd1));
        // dut 1: reset, then a 3-cycle stall interrupted by 4 busy cycles
        vecs.push_back(mk("b_rst",     1, K_RST,    1, C_RST,   2'd0, 16'd6, 16'd1));
        vecs.push_back(mk("b_run",     1, K_IDLE,   1, C_RUN,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("b_hz",      1, K_HZ,     1, C_STALL, 2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("b_busy0",   1, K_BUSY,   1, C_FRZ,   2'd1, 16'd1, 16'd0));
        vecs.push_back(mk("b_busy1",   1, K_BUSY,   1, C_FRZ,   2'd1, 16'd1, 16'd0));
        vecs.push_back(mk("b_busy2",   1, K_BUSY,   1, C_FRZ,   2'd1, 16'd1, 16'd0));
        vecs.push_back(mk("b_busy3",   1, K_BUSY,   1, C_FRZ,   2'd1, 16'd1, 16'd0));
        vecs.push_back(mk("b_stall2",  1, K_IDLE,   1, C_STALL, 2'd1, 16'd1, 16'd0));
        vecs.push_back(mk("b_stall3",  1, K_IDLE,   1, C_STALL, 2'd1, 16'd2, 16'd0));
        vecs.push_back(mk("b_end",     1, K_IDLE,   1, C_RUN,   2'd0, 16'd3, 16'd0));
        // dut 1: branch aborts a stall; flush extended by busy; hz/br ignored in FLUSH
        vecs.push_back(mk("b_hz2",     1, K_HZ,     1, C_STALL, 2'd0, 16'd3, 16'd0));
        vecs.push_back(mk("b_abort",   1, K_BR,     1, C_FLUSH, 2'd1, 16'd4, 16'd0));
        vecs.push_back(mk("b_fl_hz",   1, K_HZ,     1, C_FLUSH, 2'd2, 16'd4, 16'd1));
        vecs.push_back(mk("b_fl_busy", 1, K_BUSY,   1, C_FRZ,   2'd2, 16'd4, 16'd1));
        vecs.push_back(mk("b_fl_br",   1, K_BR,     1, C_FLUSH, 2'd2, 16'd4, 16'd1));
        vecs.push_back(mk("b_fl_end",  1, K_IDLE,   1, C_RUN,   2'd0, 16'd4, 16'd1));
        // dut 1: reset mid-stall, busy outranks branch
        vecs.push_back(mk("b_hz3",     1, K_HZ,     1, C_STALL, 2'd0, 16'd4, 16'd1));
        vecs.push_back(mk("b_midrst",  1, K_RST,    1, C_RST,   2'd1, 16'd5, 16'd1));
        vecs.push_back(mk("b_postrst", 1, K_IDLE,   1, C_RUN,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("b_busybr",  1, K_BUSYBR, 1, C_FRZ,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("b_idle",    1, K_IDLE,   1, C_RUN,   2'd0, 16'd0, 16'd0));
        // dut 2: single-cycle branch penalty
        vecs.push_back(mk("c_rst",     2, K_RST,    0, C_RST,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("c_run",     2, K_IDLE,   1, C_RUN,   2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("c_br",      2, K_BR,     1, C_FLUSH, 2'd0, 16'd0, 16'd0));
        vecs.push_back(mk("c_br_end",  2, K_IDLE,   1, C_RUN,   2'd0, 16'd0, 16'd1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // dut 2: continuous hazard drives stall_cnt into saturation
        hzv = mk("c_hold", 2, K_HZ, 1, C_STALL, 2'd0, 16'd0, 16'd0);
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            drive(hzv);
        end
        applyStimulus(mk("c_sat0", 2, K_HZ,   1, C_STALL, 2'd0, 16'hFFFF, 16'd1));
        checkOutput();
        applyStimulus(mk("c_sat1", 2, K_HZ,   1, C_STALL, 2'd0, 16'hFFFF, 16'd1));
        checkOutput();
        applyStimulus(mk("c_sat2", 2, K_IDLE, 1, C_RUN,   2'd0, 16'hFFFF, 16'd1));
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the IF/EX pipeline register and the PC. It detects load-use hazards and resolved taken branches, and generates the IF/EX write-enable, the IF/EX flush, the PC write-enable and the EX bubble. When data memory is busy, it freezes the whole front end. Two saturating performance counters track stall cycles and flush events.

## Interface
- STALL_CYCLES, 1: bubble cycles per load-use hazard; legal range 1..15.
- BRANCH_PENALTY, 1: cycles of IF/EX flush per taken branch; legal range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_busy  in  1  data memory not ready.
- pc_write_en  out  1  PC loads its next value at the edge.
- ifex_write_en  out  1  drives the IF/EX register WriteEnable.
- ifex_flush  out  1  IF/EX register loads all-zero (NOP) at the edge.
- ex_bubble  out  1  ID/EX control is zeroed at the edge.
- freeze  out  1  whole front end held; no register updates.
- state  out  2  current state: 0 = RUN, 1 = LOAD_STALL, 2 = FLUSH.
- stall_cnt  out  16  load-stall cycle count, saturating.
- flush_cnt  out  16  taken-branch flush event count, saturating.

## Operation
- Hazard definition: hz = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- State and the 4-bit down-counter cnt are registered. All control outputs are combinational from state and current inputs (Mealy).
- Priority, highest first: Reset, mem_busy, branch_taken, hz.
- Reset high:
  - pc_write_en=0, ifex_write_en=0, ifex_flush=1, ex_bubble=1, freeze=0.
  - Next state is RUN, cnt=0, stall_cnt=0, flush_cnt=0.
- mem_busy high in any state:
  - freeze=1, pc_write_en=0, ifex_write_en=0, ifex_flush=0, ex_bubble=0.
  - State, cnt and both perf counters hold.
- RUN, no event: pc_write_en=1, ifex_write_en=1, ifex_flush=0, ex_bubble=0.
- RUN with branch_taken:
  - pc_write_en=1, ifex_write_en=1, ifex_flush=1, ex_bubble=0.
  - flush_cnt increments by 1.
  - If BRANCH_PENALTY > 1: go to FLUSH with cnt=BRANCH_PENALTY-2. Otherwise stay in RUN.
  - A simultaneous hz is ignored, because the ID instruction is wrong-path.
- RUN with hz (no branch_taken):
  - pc_write_en=0, ifex_write_en=0, ifex_flush=0, ex_bubble=1.
  - stall_cnt increments by 1.
  - If STALL_CYCLES > 1: go to LOAD_STALL with cnt=STALL_CYCLES-2. Otherwise stay in RUN.
- LOAD_STALL:
  - Outputs are the same as RUN with hz; stall_cnt increments each cycle.
  - If cnt==0, go to RUN; otherwise cnt decrements.
  - hz is not re-evaluated while in this state.
  - branch_taken aborts the stall: outputs and transition follow "RUN with branch_taken" exactly.
- FLUSH:
  - pc_write_en=1, ifex_write_en=1, ifex_flush=1, ex_bubble=0.
  - branch_taken and hz are ignored.
  - If cnt==0, go to RUN; otherwise cnt decrements.
- Perf counters saturate at 16'hFFFF and never wrap.

## Timing
- Zero-cycle control latency: a hazard or branch asserted in cycle N affects the register updates at the end of cycle N.
- A load-use hazard produces exactly STALL_CYCLES cycles with ifex_write_en=0 (mem_busy cycles excluded). The stall ends with pc_write_en=1 on the following cycle.
- A taken branch produces exactly BRANCH_PENALTY consecutive cycles of ifex_flush=1 (mem_busy cycles excluded).
- mem_busy asserted mid-stall or mid-flush extends that sequence by the busy duration. No cycles are lost or repeated.
- Reset asserted mid-operation takes effect at the next edge: state=RUN, counters=0.
- After Reset is released, the first cycle is in RUN with normal outputs.

## Test plan
- Reset held for 2 cycles, then released, no hazard → during reset pc_write_en=0, ifex_flush=1; afterwards pc_write_en=1, ifex_write_en=1, state=0, stall_cnt=0, flush_cnt=0.
- STALL_CYCLES=2, ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle → ifex_write_en=0 and ex_bubble=1 for 2 cycles, state=1 in the second cycle, then RUN; stall_cnt=2.
- Same hazard but ex_rd=0, or id_rt=5 with id_uses_rt=0 → no stall; stall_cnt stays 0.
- BRANCH_PENALTY=2, branch_taken and hz together in RUN → ifex_flush=1 for 2 cycles, pc_write_en=1 throughout, no stall; flush_cnt=1, stall_cnt=0.
- STALL_CYCLES=3, hz in RUN, then mem_busy=1 for 4 cycles during LOAD_STALL → freeze=1 for 4 cycles with state and stall_cnt held; total stall cycles = 3; stall_cnt=3.
- Hazard held continuously with STALL_CYCLES=1 and stall_cnt preloaded via 65535 stall cycles → stall_cnt holds at 16'hFFFF and does not wrap.
